// File: rtl/usb_frame_scheduler.sv
// USB1.1 host transmit sequencer: frame timer, SOF/keep-alive, single token path, bus reset.
// Optional build macro USB_LS_KEEPALIVE_EN: LS mode sends a PID-only SOF as keep-alive.
module usb_frame_scheduler #(
    parameter int FRAME_CLKS    = 48000,
    parameter int RESET_CLKS    = 480000,
    parameter int RECOVERY_CLKS = 480000,
    parameter int GUARD_CLKS    = 2400
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        ls_mode_i,
    input  logic        pre_i,
    input  logic        bus_reset_i,
    input  logic        tok_valid_i,
    input  logic [3:0]  tok_pid_i,
    input  logic [6:0]  tok_addr_i,
    input  logic [3:0]  tok_ep_i,
    output logic        tok_ready_o,
    output logic        tok_done_o,
    output logic [7:0]  utmi_data_out_o,
    output logic        utmi_txvalid_o,
    input  logic        utmi_txready_i,
    input  logic        utmi_rxactive_i,
    output logic [1:0]  utmi_xcvrselect_o,
    output logic        utmi_termselect_o,
    output logic [1:0]  utmi_op_mode_o,
    output logic        utmi_dppulldown_o,
    output logic        utmi_dmpulldown_o,
    output logic        sof_o,
    output logic [10:0] frame_num_o,
    output logic        reset_active_o
);
    // state   | meaning
    // IDLE    | waiting; arbitrates bus reset, SOF, token
    // BUS_RST | driving SE0 on the bus
    // RECOVER | post-reset idle before first SOF
    // SOF_*   | SOF PID, frame low byte, {crc5, frame high}
    // TOK_*   | token PID, {ep[0], addr}, {crc5, ep[3:1]}
    typedef enum logic [3:0] {
        IDLE, BUS_RST, RECOVER, SOF_PID, SOF_B1, SOF_B2, TOK_PID, TOK_B1, TOK_B2
    } state_t;

    localparam int TW      = $clog2(FRAME_CLKS);
    localparam int DUR_MAX = (RESET_CLKS > RECOVERY_CLKS) ? RESET_CLKS : RECOVERY_CLKS;
    localparam int DW      = $clog2(DUR_MAX);
    localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_CLKS - 1);
    localparam logic [TW-1:0] TOK_LIMIT  = TW'(FRAME_CLKS - GUARD_CLKS);
    localparam logic [DW-1:0] RST_LOAD   = DW'(RESET_CLKS - 1);
    localparam logic [DW-1:0] REC_LOAD   = DW'(RECOVERY_CLKS - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q;
    logic [10:0]   frame_q;
    logic          sof_pending_q;
    logic [DW-1:0] dur_q;
    logic          bus_reset_q;
    logic          rst_edge_q;
    logic [3:0]    pid_q;
    logic [10:0]   fld_q;
    logic          sof_start;
    logic          tok_start;
    logic          counting;
    logic          wrap;
    logic [4:0]    crc_tx;

    // Returned in wire order: bit 0 is the first CRC bit on the bus.
    function automatic logic [4:0] crc5_tx(input logic [10:0] d);
        logic [4:0] c;
        c = 5'h1f;
        for (int i = 0; i < 11; i++) begin
            if (c[4] ^ d[i]) c = {c[3:0], 1'b0} ^ 5'b00101;
            else             c = {c[3:0], 1'b0};
        end
        c = ~c;
        return {c[0], c[1], c[2], c[3], c[4]};
    endfunction

    assign crc_tx   = crc5_tx(fld_q);
    assign counting = enable_i && (state_q != BUS_RST) && (state_q != RECOVER);
    assign wrap     = counting && (timer_q == TIMER_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        sof_start  = 1'b0;
        tok_start  = 1'b0;
        tok_done_o = 1'b0;
        if (rst_edge_q) begin
            state_d = BUS_RST;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i && sof_pending_q && !utmi_rxactive_i) begin
                        sof_start = 1'b1;
`ifdef USB_LS_KEEPALIVE_EN
                        state_d = SOF_PID;
`else
                        state_d = ls_mode_i ? IDLE : SOF_PID;
`endif
                    end else if (enable_i && tok_valid_i && !utmi_rxactive_i &&
                                 (timer_q < TOK_LIMIT) && !sof_pending_q) begin
                        tok_start = 1'b1;
                        state_d   = TOK_PID;
                    end
                end
                BUS_RST: if (dur_q == '0) state_d = RECOVER;
                RECOVER: if (dur_q == '0) state_d = IDLE;
                SOF_PID: begin
                    if (utmi_txready_i) begin
`ifdef USB_LS_KEEPALIVE_EN
                        state_d = ls_mode_i ? IDLE : SOF_B1;
`else
                        state_d = SOF_B1;
`endif
                    end
                end
                SOF_B1:  if (utmi_txready_i) state_d = SOF_B2;
                SOF_B2:  if (utmi_txready_i) state_d = IDLE;
                TOK_PID: if (utmi_txready_i) state_d = TOK_B1;
                TOK_B1:  if (utmi_txready_i) state_d = TOK_B2;
                TOK_B2: begin
                    if (utmi_txready_i) begin
                        state_d    = IDLE;
                        tok_done_o = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q       <= '0;
            frame_q       <= '0;
            sof_pending_q <= 1'b0;
            dur_q         <= '0;
            bus_reset_q   <= 1'b0;
            rst_edge_q    <= 1'b0;
            pid_q         <= '0;
            fld_q         <= '0;
        end else begin
            bus_reset_q <= bus_reset_i;
            rst_edge_q  <= bus_reset_i & ~bus_reset_q;

            if (rst_edge_q)                              dur_q <= RST_LOAD;
            else if (state_q == BUS_RST && dur_q == '0)  dur_q <= REC_LOAD;
            else if (dur_q != '0)                        dur_q <= dur_q - 1'b1;

            if (rst_edge_q || !enable_i) timer_q <= '0;
            else if (wrap)               timer_q <= '0;
            else if (counting)           timer_q <= timer_q + 1'b1;

            if (rst_edge_q)  frame_q <= '0;
            else if (wrap)   frame_q <= frame_q + 1'b1;

            // A wrap always wins so at most one SOF is ever owed.
            if (rst_edge_q || wrap) sof_pending_q <= 1'b1;
            else if (sof_start)     sof_pending_q <= 1'b0;

            if (sof_start) begin
                pid_q <= 4'h5;
                fld_q <= frame_q;
            end else if (tok_start) begin
                pid_q <= tok_pid_i;
                fld_q <= {tok_ep_i, tok_addr_i};
            end
        end
    end

    always_comb begin
        utmi_txvalid_o  = 1'b0;
        utmi_data_out_o = 8'h00;
        case (state_q)
            SOF_PID, TOK_PID: begin
                utmi_txvalid_o  = 1'b1;
                utmi_data_out_o = {~pid_q, pid_q};
            end
            SOF_B1, TOK_B1: begin
                utmi_txvalid_o  = 1'b1;
                utmi_data_out_o = fld_q[7:0];
            end
            SOF_B2, TOK_B2: begin
                utmi_txvalid_o  = 1'b1;
                utmi_data_out_o = {crc_tx, fld_q[10:8]};
            end
            default: ;
        endcase
    end

    always_comb begin
        utmi_termselect_o = 1'b0;
        utmi_dppulldown_o = 1'b1;
        utmi_dmpulldown_o = 1'b1;
        if (state_q == BUS_RST) begin
            utmi_xcvrselect_o = 2'b00;
            utmi_op_mode_o    = 2'b10;
        end else begin
            utmi_xcvrselect_o = ls_mode_i ? 2'b10 : (pre_i ? 2'b11 : 2'b01);
            utmi_op_mode_o    = 2'b00;
        end
    end

    assign sof_o          = sof_start;
    assign tok_ready_o    = tok_start;
    assign frame_num_o    = frame_q;
    assign reset_active_o = (state_q == BUS_RST) || (state_q == RECOVER);
endmodule

// File: tb/tb_usb_frame_scheduler.sv
// Scoreboard bench for usb_frame_scheduler with shortened frame/reset timing.
module tb_usb_frame_scheduler;
    localparam int FRAME = 600;
    localparam int RSTC  = 50;
    localparam int RECC  = 70;
    localparam int GUARD = 100;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i, ls_mode_i, pre_i, bus_reset_i;
    logic        tok_valid_i;
    logic [3:0]  tok_pid_i;
    logic [6:0]  tok_addr_i;
    logic [3:0]  tok_ep_i;
    logic        tok_ready_o, tok_done_o;
    logic [7:0]  utmi_data_out_o;
    logic        utmi_txvalid_o, utmi_txready_i, utmi_rxactive_i;
    logic [1:0]  utmi_xcvrselect_o, utmi_op_mode_o;
    logic        utmi_termselect_o, utmi_dppulldown_o, utmi_dmpulldown_o;
    logic        sof_o;
    logic [10:0] frame_num_o;
    logic        reset_active_o;

    usb_frame_scheduler #(
        .FRAME_CLKS(FRAME), .RESET_CLKS(RSTC), .RECOVERY_CLKS(RECC), .GUARD_CLKS(GUARD)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .ls_mode_i(ls_mode_i),
        .pre_i(pre_i), .bus_reset_i(bus_reset_i), .tok_valid_i(tok_valid_i),
        .tok_pid_i(tok_pid_i), .tok_addr_i(tok_addr_i), .tok_ep_i(tok_ep_i),
        .tok_ready_o(tok_ready_o), .tok_done_o(tok_done_o),
        .utmi_data_out_o(utmi_data_out_o), .utmi_txvalid_o(utmi_txvalid_o),
        .utmi_txready_i(utmi_txready_i), .utmi_rxactive_i(utmi_rxactive_i),
        .utmi_xcvrselect_o(utmi_xcvrselect_o), .utmi_termselect_o(utmi_termselect_o),
        .utmi_op_mode_o(utmi_op_mode_o), .utmi_dppulldown_o(utmi_dppulldown_o),
        .utmi_dmpulldown_o(utmi_dmpulldown_o), .sof_o(sof_o),
        .frame_num_o(frame_num_o), .reset_active_o(reset_active_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t sof_q[$];
    exp_t tok_q[$];
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0;
    int   phy_lat = 8;
    int   sof_cnt = 0, sof_cyc_last = 0, sof_end_cyc = 0;
    int   tok_rdy_cnt = 0, tok_rdy_cyc = 0, tok_done_cnt = 0, exp_done = 0;
    int   txv_cnt = 0, rstc_cnt = 0, ra_cnt = 0;
    logic [10:0] exp_sof_frame = 11'd1;
    logic cur_is_sof = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Reflected shift-right form; bit 0 of the result is sent first.
    function automatic logic [4:0] ref_crc(input logic [10:0] d);
        logic [4:0] r;
        r = 5'h1f;
        for (int i = 0; i < 11; i++) begin
            logic fb;
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ 5'h14;
        end
        return ~r;
    endfunction

    // PHY: accepts each presented byte after phy_lat cycles.
    initial begin
        int cnt;
        cnt = 0;
        utmi_txready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (utmi_txready_i) begin
                utmi_txready_i = 1'b0;
                cnt = 0;
            end else if (utmi_txvalid_o) begin
                cnt++;
                if (cnt >= phy_lat) utmi_txready_i = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    // Sampler just before each rising edge.
    initial begin
        exp_t e;
        logic [10:0] f;
        forever begin
            @(negedge clk_i);
            #2;
            if (!rst_i) begin
                if (sof_o) begin
                    check_val("sof_frame", 32'(frame_num_o), 32'(exp_sof_frame));
                    f = exp_sof_frame;
                    if (!ls_mode_i) begin
                        sof_q.push_back('{8'hA5, 1'b0});
                        sof_q.push_back('{f[7:0], 1'b0});
                        sof_q.push_back('{{ref_crc(f), f[10:8]}, 1'b1});
                    end else begin
`ifdef USB_LS_KEEPALIVE_EN
                        sof_q.push_back('{8'hA5, 1'b1});
`endif
                    end
                    exp_sof_frame = exp_sof_frame + 11'd1;
                    sof_cyc_last = cyc;
                    sof_cnt++;
                    cur_is_sof = 1'b1;
                end
                if (tok_ready_o) begin
                    tok_rdy_cnt++;
                    tok_rdy_cyc = cyc;
                    cur_is_sof = 1'b0;
                end
                if (tok_done_o) tok_done_cnt++;
                if (utmi_txvalid_o) txv_cnt++;
                if (utmi_xcvrselect_o == 2'b00 && utmi_op_mode_o == 2'b10 &&
                    utmi_dppulldown_o && utmi_dmpulldown_o) rstc_cnt++;
                if (reset_active_o) ra_cnt++;
                if (utmi_txvalid_o && utmi_txready_i) begin
                    if (cur_is_sof) begin
                        check_val("sof_byte_expected", 32'(sof_q.size() > 0), 1);
                        if (sof_q.size() > 0) begin
                            e = sof_q.pop_front();
                            check_val("sof_byte", 32'(utmi_data_out_o), 32'(e.b));
                            check_val("tok_done_in_sof", 32'(tok_done_o), 0);
                            if (e.last) sof_end_cyc = cyc;
                        end
                    end else begin
                        check_val("tok_byte_expected", 32'(tok_q.size() > 0), 1);
                        if (tok_q.size() > 0) begin
                            e = tok_q.pop_front();
                            check_val("tok_byte", 32'(utmi_data_out_o), 32'(e.b));
                            check_val("tok_done", 32'(tok_done_o), 32'(e.last));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic wait_cyc(input int t);
        if (cyc > t) check_val("sched_late", cyc, t);
        while (cyc < t) @(negedge clk_i);
    endtask

    task automatic send_tok(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep);
        logic [10:0] d;
        d = {ep, addr};
        tok_q.push_back('{{~pid, pid}, 1'b0});
        tok_q.push_back('{d[7:0], 1'b0});
        tok_q.push_back('{{ref_crc(d), d[10:8]}, 1'b1});
        exp_done++;
        tok_pid_i   = pid;
        tok_addr_i  = addr;
        tok_ep_i    = ep;
        tok_valid_i = 1'b1;
    endtask

    task automatic wait_tok_ready(input int budget);
        int c0;
        c0 = tok_rdy_cnt;
        for (int i = 0; i < budget && tok_rdy_cnt == c0; i++) @(negedge clk_i);
        check_val("tok_ready_seen", tok_rdy_cnt - c0, 1);
        tok_valid_i = 1'b0;
    endtask

    task automatic wait_sof(input int budget);
        int c0;
        c0 = sof_cnt;
        for (int i = 0; i < budget && sof_cnt == c0; i++) @(negedge clk_i);
        check_val("sof_seen", sof_cnt - c0, 1);
    endtask

    task automatic wait_quiet(input int budget);
        for (int i = 0; i < budget && (utmi_txvalid_o || sof_q.size() != 0 || tok_q.size() != 0); i++)
            @(negedge clk_i);
        check_val("quiet", 32'(sof_q.size() + tok_q.size()), 0);
    endtask

    initial begin
        int r, s1, s2, s3, s4, w, sc0, txc0;
        logic [10:0] f0;
        rst_i = 1'b1;
        enable_i = 1'b1; ls_mode_i = 1'b0; pre_i = 1'b0; bus_reset_i = 1'b0;
        tok_valid_i = 1'b0; tok_pid_i = '0; tok_addr_i = '0; tok_ep_i = '0;
        utmi_rxactive_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        check_val("rst_txvalid", 32'(utmi_txvalid_o), 0);
        check_val("rst_data", 32'(utmi_data_out_o), 0);
        check_val("rst_frame", 32'(frame_num_o), 0);
        check_val("rst_reset_active", 32'(reset_active_o), 0);
        check_val("rst_xcvr", 32'(utmi_xcvrselect_o), 1);
        check_val("rst_opmode", 32'(utmi_op_mode_o), 0);
        check_val("rst_misc", 32'({utmi_termselect_o, utmi_dppulldown_o, utmi_dmpulldown_o}), 3);
        check_val("rst_pulses", 32'({sof_o, tok_ready_o, tok_done_o}), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        r = cyc;

        // First wrap after reset carries frame 1.
        wait_sof(FRAME + 10);
        s1 = sof_cyc_last;
        check_val("first_sof_cyc", s1 - r, FRAME);

        wait_cyc(s1 + 100);
        send_tok(4'hD, 7'h00, 4'h0);
        wait_tok_ready(5);
        check_val("setup_ready_cyc", tok_rdy_cyc - s1, 100);
        wait_quiet(60);

        wait_cyc(s1 + 200);
        send_tok(4'h9, 7'h15, 4'hA);
        wait_tok_ready(5);
        wait_quiet(60);
        wait_cyc(s1 + 280);
        send_tok(4'h1, 7'h7F, 4'hF);
        wait_tok_ready(5);
        wait_quiet(60);
        wait_cyc(s1 + 360);
        send_tok(4'h9, 7'h01, 4'h1);
        wait_tok_ready(5);
        wait_quiet(60);

        wait_sof(FRAME);
        s2 = sof_cyc_last;
        check_val("sof_spacing", s2 - s1, FRAME);
        wait_quiet(60);

        // Last timer value still allowed.
        wait_cyc(s2 + FRAME - GUARD - 1);
        send_tok(4'h1, 7'h22, 4'h3);
        wait_tok_ready(5);
        check_val("guard_edge_ready_cyc", tok_rdy_cyc - s2, FRAME - GUARD - 1);
        wait_quiet(60);

        wait_sof(FRAME);
        s3 = sof_cyc_last;
        check_val("sof_spacing2", s3 - s2, FRAME);
        wait_quiet(60);
        wait_cyc(s3 + FRAME - GUARD);
        sc0 = sof_cnt;
        send_tok(4'h9, 7'h05, 4'h2);
        wait_tok_ready(GUARD + 100);
        check_val("guard_sof_first", sof_cnt - sc0, 1);
        check_val("guard_after_sof", tok_rdy_cyc - sof_end_cyc, 1);
        s4 = sof_cyc_last;
        wait_quiet(60);

        // Receive activity across the wrap defers SOF.
        wait_cyc(s4 + FRAME - 10);
        utmi_rxactive_i = 1'b1;
        wait_cyc(s4 + FRAME + 200);
        utmi_rxactive_i = 1'b0;
        r = cyc;
        wait_sof(10);
        check_val("rxactive_sof_cyc", sof_cyc_last, r);
        wait_quiet(60);

        // Bus reset in the middle of a token.
        w = s4 + FRAME;
        wait_cyc(w + 300);
        send_tok(4'h9, 7'h03, 4'h2);
        wait_tok_ready(5);
        for (int i = 0; i < 30 && tok_q.size() != 2; i++) @(negedge clk_i);
        check_val("abort_pid_sent", tok_q.size(), 2);
        bus_reset_i = 1'b1;
        rstc_cnt = 0;
        ra_cnt = 0;
        exp_sof_frame = 11'd0;
        sc0 = tok_done_cnt;
        @(negedge clk_i);
        bus_reset_i = 1'b0;
        for (int i = 0; i < 4 && utmi_txvalid_o; i++) @(negedge clk_i);
        check_val("abort_txvalid", 32'(utmi_txvalid_o), 0);
        tok_q.delete();
        exp_done--;
        wait_sof(RSTC + RECC + 20);
        check_val("abort_no_done", tok_done_cnt - sc0, 0);
        check_val("bus_rst_cycles", rstc_cnt, RSTC);
        check_val("reset_active_cycles", ra_cnt, RSTC + RECC);
        check_val("reset_active_end", 32'(reset_active_o), 0);
        wait_quiet(60);

        // Low-speed modes.
        ls_mode_i = 1'b1;
        #1 check_val("xcvr_ls", 32'(utmi_xcvrselect_o), 2);
        pre_i = 1'b1;
        #1 check_val("xcvr_ls_over_pre", 32'(utmi_xcvrselect_o), 2);
        ls_mode_i = 1'b0;
        #1 check_val("xcvr_pre", 32'(utmi_xcvrselect_o), 3);
        ls_mode_i = 1'b1;
        pre_i = 1'b0;
        @(negedge clk_i);
        txc0 = txv_cnt;
        wait_sof(FRAME + 10);
        repeat (40) @(negedge clk_i);
`ifdef USB_LS_KEEPALIVE_EN
        check_val("ls_keepalive_sent", 32'(txv_cnt > txc0), 1);
        check_val("ls_keepalive_q", sof_q.size(), 0);
`else
        check_val("ls_no_txvalid", txv_cnt - txc0, 0);
`endif
        ls_mode_i = 1'b0;
        wait_quiet(60);

        // Disabled: timer held, nothing starts.
        enable_i = 1'b0;
        sc0 = sof_cnt;
        f0 = frame_num_o;
        txc0 = tok_rdy_cnt;
        tok_pid_i = 4'h1; tok_addr_i = 7'h09; tok_ep_i = 4'h1;
        tok_valid_i = 1'b1;
        repeat (2 * FRAME + 10) @(negedge clk_i);
        check_val("disabled_no_sof", sof_cnt - sc0, 0);
        check_val("disabled_frame", 32'(frame_num_o), 32'(f0));
        check_val("disabled_no_tok", tok_rdy_cnt - txc0, 0);
        tok_valid_i = 1'b0;

        check_val("sof_q_empty", sof_q.size(), 0);
        check_val("tok_q_empty", tok_q.size(), 0);
        check_val("tok_done_count", tok_done_cnt, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
